// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
package uart_pkg;
  localparam int UART_DATA_W             = 8;
  localparam int UART_DEFAULT_BAUD       = 9_600;
  localparam int UART_DEFAULT_CLK_HZ     = 48_000_000;
  localparam int UART_FIFO_DEPTH_DEFAULT = 16;
endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with sticky overflow.
// Define UART_RX_FIFO_STATS_EN to add a saturating 16-bit drop_count output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH_DEFAULT,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  input  logic                     clear_overflow
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  // Storage is never reset, so gate the read to keep out_data at zero while empty.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (clear_overflow) begin
      drop_count <= drop ? 16'd1 : 16'd0;
    end else if (drop && drop_count != '1) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks pops.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clear_overflow = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] drop_count;
`endif

  int passed = 0;
  int total  = 0;
  logic [7:0] sb[$];
  logic [7:0] v;

  uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .full(full),
    .overflow(overflow),
    .clear_overflow(clear_overflow)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accepted);
    in_valid = 1'b1;
    in_data  = b;
    if (accepted) sb.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  // Monitor: a handshake seen on the falling edge is what the next rising edge pops.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_pop: got %0h expected no output", out_data);
        end else begin
          chk("pop_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    reset = 1'b0;
    tick();

    // Basic push then drain
    push_byte(8'h41, 1'b1);
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    chk("t1_count", {27'd0, count}, 32'd3);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data", {24'd0, out_data}, 32'h41);
    chk("t1_full", {31'd0, full}, 32'd0);
    chk("t1_ovf", {31'd0, overflow}, 32'd0);
    drain(3);
    chk("t1_count_end", {27'd0, count}, 32'd0);
    chk("t1_valid_end", {31'd0, out_valid}, 32'd0);

    // Empty + out_ready is ignored
    drain(2);
    chk("empty_rdy_count", {27'd0, count}, 32'd0);

    // Fill to full and overflow
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_count16", {27'd0, count}, 32'd16);
    chk("t2_ovf_before", {31'd0, overflow}, 32'd0);
    push_byte(8'h10, 1'b0);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_count_after_drop", {27'd0, count}, 32'd16);
    chk("t2_head", {24'd0, out_data}, 32'h00);
`ifdef UART_RX_FIFO_STATS_EN
    chk("t2_drops", {16'd0, drop_count}, 32'd1);
`endif

    // Drop coinciding with clear: set wins
    clear_overflow = 1'b1;
    push_byte(8'h99, 1'b0);
    clear_overflow = 1'b0;
    chk("set_wins_ovf", {31'd0, overflow}, 32'd1);
`ifdef UART_RX_FIFO_STATS_EN
    chk("set_wins_drops", {16'd0, drop_count}, 32'd1);
`endif
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clear_ovf", {31'd0, overflow}, 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
    chk("clear_drops", {16'd0, drop_count}, 32'd0);
`endif

    // Push and pop together at full
    out_ready = 1'b1;
    push_byte(8'hAA, 1'b1);
    out_ready = 1'b0;
    chk("t3_count", {27'd0, count}, 32'd16);
    chk("t3_ovf", {31'd0, overflow}, 32'd0);
    chk("t3_head", {24'd0, out_data}, 32'h01);
    drain(16);
    chk("t3_count_end", {27'd0, count}, 32'd0);

    // Interleaved traffic across pointer wrap
    v = 8'h80;
    for (int i = 0; i < 3; i++) begin
      push_byte(v, 1'b1);
      v++;
    end
    for (int i = 0; i < 40; i++) begin
      in_valid  = (i % 4 != 3);
      out_ready = (i % 4 != 1);
      if (in_valid) begin
        in_data = v;
        sb.push_back(v);
        v++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t4_count", {27'd0, count}, 32'd3);
    drain(3);
    chk("t4_count_end", {27'd0, count}, 32'd0);

    // Reset mid-stream at count 7 with overflow set
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i), 1'b1);
    push_byte(8'hEE, 1'b0);
    drain(9);
    chk("t5_count7", {27'd0, count}, 32'd7);
    chk("t5_ovf_pre", {31'd0, overflow}, 32'd1);
    reset = 1'b1;
    sb.delete();
    tick();
    chk("t5_count", {27'd0, count}, 32'd0);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_ovf", {31'd0, overflow}, 32'd0);
    chk("t5_full", {31'd0, full}, 32'd0);
    reset = 1'b0;
    tick();
    push_byte(8'h55, 1'b1);
    chk("t5_data", {24'd0, out_data}, 32'h55);
    chk("t5_count1", {27'd0, count}, 32'd1);
    drain(1);

    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Byte buffer directly downstream of the UART receiver.
- Captures each single-cycle `data_ready` pulse with its 8-bit byte into a DEPTH-entry circular buffer.
- Presents bytes in arrival order to the consumer over a valid/ready interface.
- Decouples the consumer's processing rate from line rate; flags bytes lost to overflow.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2.
- DATA_W, 8, byte width; matches the receiver data width.

Ports:
- clk  input  1  system clock (48 MHz).
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_W  byte from the receiver's data_out.
- in_valid  input  1  single-cycle strobe from the receiver's data_ready.
- out_data  output  DATA_W  oldest buffered byte; valid only while out_valid=1.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: at least one byte was dropped.
- clear_overflow  input  1  synchronous clear of overflow (and drop_count when present).

Behaviour:
- Reset (async assert, sync-released by the system):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, full=0, overflow=0, out_data=0.
  - Storage contents need no reset.
  - Reset mid-operation flushes all buffered bytes.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; no explicit modulo logic.
- Push: occurs when in_valid=1 and (count<DEPTH, or a pop occurs in the same cycle).
  - mem[wr_ptr] <= in_data; wr_ptr increments.
- Pop: occurs when out_valid=1 and out_ready=1.
  - rd_ptr increments.
- Output path is first-word-fall-through:
  - out_data = mem[rd_ptr], read combinationally from the register array; no extra output register.
  - out_valid = (count != 0), decoded from registered count.
- Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N; consumer can pop it in cycle N+1.
- Count update per cycle:
  - push only: count+1.
  - pop only: count-1.
  - both: unchanged.
  - neither: unchanged.
- Full + in_valid + pop in the same cycle: byte accepted, count stays DEPTH, no overflow.
- Full + in_valid, no pop: byte dropped; storage, pointers and count unchanged; overflow <= 1.
- Empty + out_ready: no pop, no pointer change.
- out_ready with out_valid=0 is ignored.
- Overflow flag:
  - Set on any dropped byte.
  - Cleared by clear_overflow=1.
  - If a drop and clear_overflow coincide, set wins; overflow=1 next cycle.
- full is a registered-state decode (count==DEPTH); no combinational path from in_valid or out_ready to full, count or out_valid.
- in_valid held high for multiple cycles pushes one byte per cycle. The receiver never does this, but the FIFO handles it.

Optional Feature:
- Macro: UART_RX_FIFO_STATS_EN.
- Defined:
  - Adds output port drop_count, 16 bits, reset 0.
  - Increments by 1 per dropped byte and saturates at 16'hFFFF.
  - clear_overflow clears it to 0; if a drop coincides with the clear, drop_count becomes 1.
- Undefined: drop_count port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W = 8.
  - UART_DEFAULT_BAUD = 9_600.
  - UART_DEFAULT_CLK_HZ = 48_000_000.
  - UART_FIFO_DEPTH_DEFAULT = 16.
- This block uses UART_DATA_W for the DATA_W default.
- No sub-module. Storage, pointers and count stay inline; the design is too small to justify a split.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate cycles with out_ready=0 -> count=3, out_valid=1, out_data=0x41, full=0, overflow=0.
- Then hold out_ready=1 for 3 cycles -> out_data sequence 0x41, 0x42, 0x43; count ends at 0; out_valid=0.
- Push 17 bytes 0x00..0x10 with DEPTH=16, out_ready=0 -> full=1 after the 16th; 0x10 dropped; overflow=1. Drain yields 0x00..0x0F only. With STATS_EN, drop_count=1.
- At full, assert in_valid=1 (0xAA) and out_ready=1 in the same cycle -> count stays 16; overflow stays 0; after draining 15 bytes, 0xAA is last out.
- Wrap test: 40 push/pop pairs of an incrementing byte, pushes and pops interleaved at count 1..5 -> output order matches input; pointers wrap with no loss.
- Assert reset mid-stream at count=7 with overflow=1 -> next edge: count=0, out_valid=0, overflow=0, full=0. A subsequent push of 0x55 appears as out_data=0x55.
